seq_pattern_tx: RTL and testbench

//  Serial pattern transmitter; the driving end of the 1-bit serial sequence detector.

---
 rtl/seq_pattern_tx.sv | 142 ++++++++++++++
 tb/tb_seq_pattern_tx.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a PAT_W-bit pattern out MSB-first,
// repeating it with an idle gap between copies, then pulses done.
module seq_pattern_tx #(
    parameter int             PAT_W   = 6,
    parameter logic [PAT_W-1:0] PATTERN = 6'b101011,
    parameter int             GAP_LEN = 2,
    parameter int             CNT_W   = 4
) (
    input  logic             BTND,
    input  logic             reset,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             start,
    input  logic [CNT_W-1:0] reps,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done,
    output logic [2:0]       bit_idx,
    output logic [CNT_W-1:0] rep_left
);

    localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam logic [2:0] MSB = 3'(PAT_W - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t           state, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] sh, sh_d;
    logic [PAT_W-1:0] src;
    logic [GW-1:0]    gap_cnt, gc_d;
    logic             so_d, sv_d, busy_d, done_d;
    logic [2:0]       idx_d;
    logic [CNT_W-1:0] rl_d;

    always_ff @(posedge BTND) begin
        if (reset) begin
            state     <= IDLE;
            pat_q     <= PATTERN;
            sh        <= '0;
            gap_cnt   <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bit_idx   <= '0;
            rep_left  <= '0;
        end else begin
            state     <= state_d;
            pat_q     <= pat_d;
            sh        <= sh_d;
            gap_cnt   <= gc_d;
            ser_out   <= so_d;
            ser_valid <= sv_d;
            busy      <= busy_d;
            done      <= done_d;
            bit_idx   <= idx_d;
            rep_left  <= rl_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (start) state_d = SEND;
            SEND: begin
                if (bit_idx == 3'd0) begin
                    if (rep_left > CNT_W'(1))
                        state_d = (GAP_LEN > 0) ? GAP : SEND;
                    else
                        state_d = DONE;
                end
            end
            GAP:  if (gap_cnt == '0) state_d = SEND;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pat_d  = pat_q;
        sh_d   = sh;
        gc_d   = gap_cnt;
        so_d   = ser_out;
        sv_d   = ser_valid;
        idx_d  = bit_idx;
        rl_d   = rep_left;
        done_d = 1'b0;
        busy_d = (state_d == SEND) || (state_d == GAP);
        src    = load ? pat_in : pat_q;
        unique case (state)
            IDLE: begin
                if (load) pat_d = pat_in;
                if (start) begin
                    sh_d  = src;
                    so_d  = src[PAT_W-1];
                    sv_d  = 1'b1;
                    idx_d = MSB;
                    rl_d  = (reps == '0) ? CNT_W'(1) : reps;
                end
            end
            SEND: begin
                if (bit_idx != 3'd0) begin
                    // rotate rather than shift; only the upper bits are ever read
                    sh_d  = {sh[PAT_W-2:0], sh[PAT_W-1]};
                    so_d  = sh[PAT_W-2];
                    idx_d = bit_idx - 3'd1;
                end else if (rep_left > CNT_W'(1)) begin
                    rl_d = rep_left - CNT_W'(1);
                    if (GAP_LEN > 0) begin
                        sv_d = 1'b0;
                        so_d = 1'b0;
                        gc_d = GW'(GAP_LEN - 1);
                    end else begin
                        sh_d  = pat_q;
                        so_d  = pat_q[PAT_W-1];
                        idx_d = MSB;
                    end
                end else begin
                    sv_d   = 1'b0;
                    so_d   = 1'b0;
                    rl_d   = '0;
                    done_d = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    sh_d  = pat_q;
                    so_d  = pat_q[PAT_W-1];
                    sv_d  = 1'b1;
                    idx_d = MSB;
                end else begin
                    gc_d = gap_cnt - GW'(1);
                end
            end
            DONE: ;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Randomised self-checking bench for seq_pattern_tx against a
// per-cycle expected-output model built from the pattern/reps/gap rules.
module tb_seq_pattern_tx;

    localparam int N = 64;
    localparam logic [5:0] DEF_PAT = 6'b101011;

    logic       BTND = 1'b0;
    logic       reset, load, start;
    logic [5:0] pat_in;
    logic [3:0] reps;
    logic       ser_out, ser_valid, busy, done;
    logic [2:0] bit_idx;
    logic [3:0] rep_left;

    logic       start0;
    logic [3:0] reps0;
    logic       ser_out0, ser_valid0, busy0, done0;
    logic [2:0] bit_idx0;
    logic [3:0] rep_left0;

    int chk = 0;
    int nfail = 0;
    logic [5:0] cur_pat;

    logic       st [N], ld [N], rs [N], st0 [N];
    logic [5:0] pi [N];
    logic       o_v [N], o_s [N], o_b [N], o_d [N];
    logic [2:0] o_i [N];
    logic [3:0] o_r [N];
    logic       o0_v [N], o0_s [N], o0_d [N], o_det [N];
    logic       e_v [N], e_s [N], e_b [N], e_d [N];
    logic [2:0] e_i [N];
    logic [3:0] e_r [N];

    logic [5:0] win;
    int         wcnt;
    logic       det;

    always #5 BTND = ~BTND;

    seq_pattern_tx dut (
        .BTND(BTND), .reset(reset), .load(load), .pat_in(pat_in),
        .start(start), .reps(reps), .ser_out(ser_out),
        .ser_valid(ser_valid), .busy(busy), .done(done),
        .bit_idx(bit_idx), .rep_left(rep_left)
    );

    seq_pattern_tx #(.GAP_LEN(0)) dut0 (
        .BTND(BTND), .reset(reset), .load(1'b0), .pat_in(6'b0),
        .start(start0), .reps(reps0), .ser_out(ser_out0),
        .ser_valid(ser_valid0), .busy(busy0), .done(done0),
        .bit_idx(bit_idx0), .rep_left(rep_left0)
    );

    // sliding-window detector fed by the gapless instance
    always @(posedge BTND) begin
        if (reset) begin
            win <= '0; wcnt <= 0; det <= 1'b0;
        end else if (ser_valid0) begin
            win <= {win[4:0], ser_out0};
            if (wcnt < 6) wcnt <= wcnt + 1;
            det <= ({win[4:0], ser_out0} == DEF_PAT) && (wcnt >= 5);
        end else begin
            det <= 1'b0;
        end
    end

    task automatic clear_stim(input logic [5:0] p);
        for (int i = 0; i < N; i++) begin
            st[i] = 0; ld[i] = 0; rs[i] = 0; st0[i] = 0; pi[i] = p;
        end
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge BTND);
            start = st[i]; load = ld[i]; reset = rs[i];
            start0 = st0[i]; pat_in = pi[i];
            @(posedge BTND);
            #1;
            o_v[i] = ser_valid; o_s[i] = ser_out; o_b[i] = busy;
            o_d[i] = done; o_i[i] = bit_idx; o_r[i] = rep_left;
            o0_v[i] = ser_valid0; o0_s[i] = ser_out0; o0_d[i] = done0;
            o_det[i] = det;
        end
        @(negedge BTND);
        start = 0; load = 0; reset = 0; start0 = 0;
    endtask

    task automatic clear_exp(input int off);
        for (int i = off; i < N; i++) begin
            e_v[i] = 0; e_s[i] = 0; e_b[i] = 0;
            e_d[i] = 0; e_i[i] = 0; e_r[i] = 0;
        end
    endtask

    // expected outputs for a run whose start is sampled at capture index off
    task automatic build_exp(input logic [5:0] p, input int rp,
                             input int g, input int off);
        int r;
        int k;
        r = (rp == 0) ? 1 : rp;
        k = off;
        clear_exp(off);
        for (int q = 0; q < r; q++) begin
            for (int b = 5; b >= 0; b--) begin
                e_v[k] = 1; e_s[k] = p[b]; e_i[k] = 3'(b);
                e_r[k] = 4'(r - q); e_b[k] = 1; k++;
            end
            if (q < r - 1)
                for (int j = 0; j < g; j++) begin
                    e_b[k] = 1; e_r[k] = 4'(r - q - 1); k++;
                end
        end
        e_d[k] = 1;
    endtask

    task automatic test_reset();
        clear_stim(6'h00);
        rs[0] = 1;
        capture(3);
        clear_exp(0);
        for (int i = 0; i < 3; i++) begin
            chk++;
            if ({o_v[i], o_s[i], o_b[i], o_d[i], o_i[i], o_r[i]} !==
                {e_v[i], e_s[i], e_b[i], e_d[i], e_i[i], e_r[i]}) begin
                nfail++;
                $display("FAIL reset cyc %0d: got v%b s%b b%b d%b i%0d r%0d want all 0",
                         i, o_v[i], o_s[i], o_b[i], o_d[i], o_i[i], o_r[i]);
            end
        end
        cur_pat = DEF_PAT;
    endtask

    task automatic test_single();
        clear_stim(6'h00);
        reps = 4'd1; st[0] = 1;
        capture(10);
        build_exp(cur_pat, 1, 2, 0);
        for (int i = 0; i < 10; i++) begin
            chk++;
            if ({o_v[i], o_s[i], o_b[i], o_d[i], o_i[i], o_r[i]} !==
                {e_v[i], e_s[i], e_b[i], e_d[i], e_i[i], e_r[i]}) begin
                nfail++;
                $display("FAIL single cyc %0d: got v%b s%b b%b d%b i%0d r%0d want v%b s%b b%b d%b i%0d r%0d",
                         i, o_v[i], o_s[i], o_b[i], o_d[i], o_i[i], o_r[i],
                         e_v[i], e_s[i], e_b[i], e_d[i], e_i[i], e_r[i]);
            end
        end
    endtask

    task automatic test_load_reps2();
        clear_stim(6'b110010);
        ld[0] = 1;
        capture(2);
        cur_pat = 6'b110010;
        clear_stim(6'h3f);
        reps = 4'd2; st[0] = 1;
        capture(18);
        build_exp(cur_pat, 2, 2, 0);
        for (int i = 0; i < 18; i++) begin
            chk++;
            if ({o_v[i], o_s[i], o_b[i], o_d[i], o_i[i], o_r[i]} !==
                {e_v[i], e_s[i], e_b[i], e_d[i], e_i[i], e_r[i]}) begin
                nfail++;
                $display("FAIL reps2 cyc %0d: got v%b s%b b%b d%b i%0d r%0d want v%b s%b b%b d%b i%0d r%0d",
                         i, o_v[i], o_s[i], o_b[i], o_d[i], o_i[i], o_r[i],
                         e_v[i], e_s[i], e_b[i], e_d[i], e_i[i], e_r[i]);
            end
        end
    endtask

    task automatic test_reps0_ignore_start();
        clear_stim(6'h00);
        reps = 4'd0;
        st[0] = 1; st[3] = 1; st[7] = 1; st[8] = 1;
        capture(18);
        build_exp(cur_pat, 0, 2, 0);
        build_exp(cur_pat, 0, 2, 8);
        for (int i = 0; i < 18; i++) begin
            chk++;
            if ({o_v[i], o_s[i], o_b[i], o_d[i], o_i[i], o_r[i]} !==
                {e_v[i], e_s[i], e_b[i], e_d[i], e_i[i], e_r[i]}) begin
                nfail++;
                $display("FAIL reps0 cyc %0d: got v%b s%b b%b d%b i%0d r%0d want v%b s%b b%b d%b i%0d r%0d",
                         i, o_v[i], o_s[i], o_b[i], o_d[i], o_i[i], o_r[i],
                         e_v[i], e_s[i], e_b[i], e_d[i], e_i[i], e_r[i]);
            end
        end
    endtask

    task automatic test_load_start_same();
        clear_stim(6'b011101);
        reps = 4'd1;
        st[0] = 1; ld[0] = 1;
        ld[3] = 1; pi[3] = 6'b000111;
        st[10] = 1;
        capture(20);
        cur_pat = 6'b011101;
        build_exp(cur_pat, 1, 2, 0);
        build_exp(cur_pat, 1, 2, 10);
        for (int i = 0; i < 20; i++) begin
            chk++;
            if ({o_v[i], o_s[i], o_b[i], o_d[i], o_i[i], o_r[i]} !==
                {e_v[i], e_s[i], e_b[i], e_d[i], e_i[i], e_r[i]}) begin
                nfail++;
                $display("FAIL ldstart cyc %0d: got v%b s%b b%b d%b i%0d r%0d want v%b s%b b%b d%b i%0d r%0d",
                         i, o_v[i], o_s[i], o_b[i], o_d[i], o_i[i], o_r[i],
                         e_v[i], e_s[i], e_b[i], e_d[i], e_i[i], e_r[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_stim(6'h00);
        reps = 4'd3; st[0] = 1; rs[3] = 1;
        capture(24);
        build_exp(cur_pat, 3, 2, 0);
        clear_exp(3);
        for (int i = 0; i < 24; i++) begin
            chk++;
            if ({o_v[i], o_s[i], o_b[i], o_d[i], o_i[i], o_r[i]} !==
                {e_v[i], e_s[i], e_b[i], e_d[i], e_i[i], e_r[i]}) begin
                nfail++;
                $display("FAIL rstmid cyc %0d: got v%b s%b b%b d%b i%0d r%0d want v%b s%b b%b d%b i%0d r%0d",
                         i, o_v[i], o_s[i], o_b[i], o_d[i], o_i[i], o_r[i],
                         e_v[i], e_s[i], e_b[i], e_d[i], e_i[i], e_r[i]);
            end
        end
        cur_pat = DEF_PAT;
        clear_stim(6'h00);
        reps = 4'd1; st[0] = 1;
        capture(9);
        build_exp(cur_pat, 1, 2, 0);
        for (int i = 0; i < 9; i++) begin
            chk++;
            if ({o_v[i], o_s[i], o_b[i], o_d[i], o_i[i], o_r[i]} !==
                {e_v[i], e_s[i], e_b[i], e_d[i], e_i[i], e_r[i]}) begin
                nfail++;
                $display("FAIL rstpat cyc %0d: got v%b s%b b%b d%b i%0d r%0d want v%b s%b b%b d%b i%0d r%0d",
                         i, o_v[i], o_s[i], o_b[i], o_d[i], o_i[i], o_r[i],
                         e_v[i], e_s[i], e_b[i], e_d[i], e_i[i], e_r[i]);
            end
        end
    endtask

    task automatic test_random();
        int rp;
        int r;
        int len;
        logic [5:0] np;
        for (int t = 0; t < 8; t++) begin
            rp = $urandom_range(0, 4);
            np = 6'($urandom);
            clear_stim(np);
            reps = 4'(rp);
            st[0] = 1;
            ld[0] = 1'($urandom);
            if (ld[0]) cur_pat = np;
            r = (rp == 0) ? 1 : rp;
            len = r * 6 + (r - 1) * 2 + 3;
            capture(len);
            build_exp(cur_pat, rp, 2, 0);
            for (int i = 0; i < len; i++) begin
                chk++;
                if ({o_v[i], o_s[i], o_b[i], o_d[i], o_i[i], o_r[i]} !==
                    {e_v[i], e_s[i], e_b[i], e_d[i], e_i[i], e_r[i]}) begin
                    nfail++;
                    $display("FAIL rand%0d cyc %0d: got v%b s%b b%b d%b i%0d r%0d want v%b s%b b%b d%b i%0d r%0d",
                             t, i, o_v[i], o_s[i], o_b[i], o_d[i], o_i[i], o_r[i],
                             e_v[i], e_s[i], e_b[i], e_d[i], e_i[i], e_r[i]);
                end
            end
        end
    endtask

    task automatic test_loopback();
        logic want_det;
        clear_stim(6'h00);
        reps0 = 4'd2; st0[0] = 1;
        capture(16);
        build_exp(DEF_PAT, 2, 0, 0);
        for (int i = 0; i < 16; i++) begin
            want_det = (i == 6) || (i == 12);
            chk++;
            if ({o0_v[i], o0_s[i], o0_d[i], o_det[i]} !==
                {e_v[i], e_s[i], e_d[i], want_det}) begin
                nfail++;
                $display("FAIL loopback cyc %0d: got v%b s%b d%b det%b want v%b s%b d%b det%b",
                         i, o0_v[i], o0_s[i], o0_d[i], o_det[i],
                         e_v[i], e_s[i], e_d[i], want_det);
            end
        end
    endtask

    initial begin
        reset = 1; load = 0; start = 0; start0 = 0;
        pat_in = '0; reps = '0; reps0 = '0;
        cur_pat = DEF_PAT;
        test_reset();
        test_single();
        test_load_reps2();
        test_reps0_ignore_start();
        test_load_start_same();
        test_reset_mid();
        test_random();
        test_loopback();
        $display("End of test - %0d assertions evaluated, %0d failures", chk, nfail);
        $finish;
    end

endmodule
